// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the two-channel push-button input conditioner.
package input_conditioner_pkg;

    // Debounce FSM encoding. Bit 1 is the accepted level in every state.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        HELD_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } db_state_e;

    // Defaults for a board clock in the tens of MHz (about 1 ms of settle time).
    localparam int unsigned DEFAULT_CNT_W           = 16;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, 4-state accept/reject FSM and a
// stability counter. The level and the press pulse come straight from flops.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int unsigned CNT_W           = DEFAULT_CNT_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    // Terminal count: the WAIT states are left on this value, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Bring the asynchronous button into the clk domain.
    // NOTE: the synchroniser flops are reset as well, so a reset mid-debounce
    // discards any in-flight sample and the channel restarts from a known 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            // NOTE: non-blocking so each flop captures the value from before the edge.
            sync_q <= {sync_q[0], raw};
        end
    end

    assign s = sync_q[1];

    // FSM, counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic: any reversal in a WAIT state restarts from the stable side.
    always_comb begin
        // NOTE: hold-value defaults first so no branch leaves a signal unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD_HIGH;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = HELD_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Accepted level is high in HELD_HIGH and WAIT_LOW; decoded from the state flops only.
    assign level = (state_q == HELD_HIGH) || (state_q == WAIT_LOW);
    assign pulse = pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// Two independent debounced button channels feeding the falling-edge
// sequential block. All outputs change on rising clk, so they are settled
// half a period before the downstream flops sample them.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned CNT_W           = DEFAULT_CNT_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_a,
    input  logic btn_b,
    output logic a_out,
    output logic b_out,
    output logic a_pulse,
    output logic b_pulse
);

    debounce_channel #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_a),
        .level (a_out),
        .pulse (a_pulse)
    );

    debounce_channel #(
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_b),
        .level (b_out),
        .pulse (b_pulse)
    );

endmodule
